// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 stream engine and its S-box.
// State classification helpers feed the registered done/busy flags.
package rc4_pkg;

    localparam int SBOX_DEPTH = 256;
    localparam int KSA_CYCLES = 512;
    localparam int PRGA_STEP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT      = 4'd1,
        ST_KSA_J     = 4'd2,
        ST_KSA_SWAP  = 4'd3,
        ST_DROP_I    = 4'd4,
        ST_DROP_J    = 4'd5,
        ST_DROP_SWAP = 4'd6,
        ST_PRGA_I    = 4'd7,
        ST_PRGA_J    = 4'd8,
        ST_PRGA_SWAP = 4'd9,
        ST_PRGA_HOLD = 4'd10
    } rc4_state_e;

    function automatic logic is_prga(input rc4_state_e s);
        return (s == ST_PRGA_I) || (s == ST_PRGA_J) ||
               (s == ST_PRGA_SWAP) || (s == ST_PRGA_HOLD);
    endfunction

    function automatic logic is_keying(input rc4_state_e s);
        return (s == ST_INIT) || (s == ST_KSA_J) || (s == ST_KSA_SWAP) ||
               (s == ST_DROP_I) || (s == ST_DROP_J) || (s == ST_DROP_SWAP);
    endfunction

endpackage

// File: rtl/rc4_stream_engine_if.sv
// Byte-stream handshake between the datapath and one RC4 engine channel.
// The master drives plaintext and the downstream ready; the engine is the slave.
interface rc4_stream_engine_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/rc4_sbox.sv
// 256x8 RC4 permutation state with three combinational read ports,
// a single-cycle swap write and a parallel identity load.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       swap,
    input  logic [7:0] addr_i,
    input  logic [7:0] addr_j,
    input  logic [7:0] addr_t,
    output logic [7:0] rd_i,
    output logic [7:0] rd_j,
    output logic [7:0] rd_t
);

    logic [7:0] s_r [SBOX_DEPTH];

    assign rd_i = s_r[addr_i];
    assign rd_j = s_r[addr_j];

    // The t read reflects the swap happening this cycle, so it sees the post-swap array
    always_comb begin
        if (addr_t == addr_i) begin
            rd_t = rd_j;
        end else if (addr_t == addr_j) begin
            rd_t = rd_i;
        end else begin
            rd_t = s_r[addr_t];
        end
    end

    // Array storage: clear, identity load, or swap of S[i] and S[j]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < SBOX_DEPTH; n++) begin
                s_r[n] <= 8'd0;
            end
        end else if (init) begin
            for (int n = 0; n < SBOX_DEPTH; n++) begin
                s_r[n] <= 8'(n);
            end
        end else if (swap) begin
            s_r[addr_i] <= rd_j;
            s_r[addr_j] <= rd_i;
        end
    end

endmodule

// File: rtl/rc4_stream_engine.sv
// RC4 engine: KSA over a 1..MAX_KEY_BYTES key, optional drop of DROP_N bytes,
// then one keystream byte every three cycles XORed onto a valid/ready stream.
module rc4_stream_engine
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16,
    parameter int DROP_N        = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [7:0]                 key_length,
    rc4_stream_engine_if.slave         strm,
    output logic [7:0]                 ckey,
    output logic                       done,
    output logic                       busy,
    output logic                       err
);

    localparam int KIDX_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;

    rc4_state_e                 state_r;
    rc4_state_e                 state_next_s;
    logic [7:0]                 i_r;
    logic [7:0]                 i_next_s;
    logic [7:0]                 j_r;
    logic [7:0]                 j_next_s;
    logic [KIDX_W-1:0]          kidx_r;
    logic [KIDX_W-1:0]          kidx_next_s;
    logic [11:0]                drop_cnt_r;
    logic [11:0]                drop_cnt_next_s;
    logic [7:0]                 len_r;
    logic [MAX_KEY_BYTES*8-1:0] key_r;
    logic [7:0]                 key_bytes_s [MAX_KEY_BYTES];
    logic [7:0]                 key_byte_s;
    logic [7:0]                 ks_r;
    logic                       ks_valid_r;
    logic [7:0]                 out_data_r;
    logic                       out_valid_r;
    logic [7:0]                 ckey_r;
    logic                       done_r;
    logic                       busy_r;
    logic                       err_r;
    logic                       sbox_init_s;
    logic                       sbox_swap_s;
    logic                       ks_gen_s;
    logic [7:0]                 s_i_s;
    logic [7:0]                 s_j_s;
    logic [7:0]                 s_t_s;
    logic [7:0]                 t_addr_s;
    logic                       start_bad_s;
    logic                       start_ok_s;
    logic                       in_ready_s;
    logic                       xfer_s;
    logic                       kidx_last_s;

    for (genvar g = 0; g < MAX_KEY_BYTES; g++) begin : g_key_bytes
        assign key_bytes_s[g] = key_r[g*8 +: 8];
    end

    assign key_byte_s  = key_bytes_s[kidx_r];
    assign kidx_last_s = (8'(kidx_r) == (len_r - 8'd1));
    assign t_addr_s    = s_i_s + s_j_s;
    assign start_bad_s = start & ((key_length == 8'd0) | (key_length > 8'(MAX_KEY_BYTES)));
    assign start_ok_s  = start & ~start_bad_s;
    assign in_ready_s  = done_r & ks_valid_r & (~out_valid_r | strm.out_ready);
    assign xfer_s      = strm.in_valid & in_ready_s;

    assign strm.in_ready  = in_ready_s;
    assign strm.out_valid = out_valid_r;
    assign strm.out_data  = out_data_r;
    assign ckey           = ckey_r;
    assign done           = done_r;
    assign busy           = busy_r;
    assign err            = err_r;

    rc4_sbox u_sbox (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (sbox_init_s),
        .swap   (sbox_swap_s),
        .addr_i (i_r),
        .addr_j (j_r),
        .addr_t (t_addr_s),
        .rd_i   (s_i_s),
        .rd_j   (s_j_s),
        .rd_t   (s_t_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, index updates and S-box strobes; a legal start overrides everything
    always_comb begin
        state_next_s    = state_r;
        i_next_s        = i_r;
        j_next_s        = j_r;
        kidx_next_s     = kidx_r;
        drop_cnt_next_s = drop_cnt_r;
        sbox_init_s     = 1'b0;
        sbox_swap_s     = 1'b0;
        ks_gen_s        = 1'b0;
        if (start_ok_s) begin
            state_next_s = ST_INIT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_INIT: begin
                    sbox_init_s     = 1'b1;
                    i_next_s        = 8'd0;
                    j_next_s        = 8'd0;
                    kidx_next_s     = '0;
                    drop_cnt_next_s = 12'd0;
                    state_next_s    = ST_KSA_J;
                end
                ST_KSA_J: begin
                    j_next_s     = j_r + s_i_s + key_byte_s;
                    state_next_s = ST_KSA_SWAP;
                end
                ST_KSA_SWAP: begin
                    sbox_swap_s = 1'b1;
                    kidx_next_s = kidx_last_s ? '0 : kidx_r + 1'b1;
                    if (i_r == 8'd255) begin
                        i_next_s     = 8'd0;
                        j_next_s     = 8'd0;
                        state_next_s = (DROP_N > 0) ? ST_DROP_I : ST_PRGA_I;
                    end else begin
                        i_next_s     = i_r + 8'd1;
                        state_next_s = ST_KSA_J;
                    end
                end
                ST_DROP_I: begin
                    i_next_s     = i_r + 8'd1;
                    state_next_s = ST_DROP_J;
                end
                ST_DROP_J: begin
                    j_next_s     = j_r + s_i_s;
                    state_next_s = ST_DROP_SWAP;
                end
                ST_DROP_SWAP: begin
                    sbox_swap_s = 1'b1;
                    if (drop_cnt_r == 12'(DROP_N - 1)) begin
                        state_next_s = ST_PRGA_I;
                    end else begin
                        drop_cnt_next_s = drop_cnt_r + 12'd1;
                        state_next_s    = ST_DROP_I;
                    end
                end
                ST_PRGA_I: begin
                    // Only one keystream byte may be buffered; park until it is taken
                    if (ks_valid_r && !xfer_s) begin
                        state_next_s = ST_PRGA_HOLD;
                    end else begin
                        i_next_s     = i_r + 8'd1;
                        state_next_s = ST_PRGA_J;
                    end
                end
                ST_PRGA_J: begin
                    j_next_s     = j_r + s_i_s;
                    state_next_s = ST_PRGA_SWAP;
                end
                ST_PRGA_SWAP: begin
                    sbox_swap_s  = 1'b1;
                    ks_gen_s     = 1'b1;
                    state_next_s = ST_PRGA_I;
                end
                ST_PRGA_HOLD: begin
                    if (!ks_valid_r || xfer_s) begin
                        state_next_s = ST_PRGA_I;
                    end else begin
                        state_next_s = ST_PRGA_HOLD;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: indices, key latch, keystream buffer, output register and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r         <= 8'd0;
            j_r         <= 8'd0;
            kidx_r      <= '0;
            drop_cnt_r  <= 12'd0;
            len_r       <= 8'd0;
            key_r       <= '0;
            ks_r        <= 8'd0;
            ks_valid_r  <= 1'b0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            ckey_r      <= 8'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            i_r        <= i_next_s;
            j_r        <= j_next_s;
            kidx_r     <= kidx_next_s;
            drop_cnt_r <= drop_cnt_next_s;
            done_r     <= is_prga(state_next_s);
            busy_r     <= is_keying(state_next_s);
            err_r      <= start_bad_s;
            if (start_ok_s) begin
                key_r       <= key;
                len_r       <= key_length;
                ks_valid_r  <= 1'b0;
                out_valid_r <= 1'b0;
                out_data_r  <= 8'd0;
                ckey_r      <= 8'd0;
            end else begin
                if (ks_gen_s) begin
                    ks_r       <= s_t_s;
                    ks_valid_r <= 1'b1;
                end else if (xfer_s) begin
                    ks_valid_r <= 1'b0;
                end
                if (xfer_s) begin
                    out_data_r  <= strm.in_data ^ ks_r;
                    ckey_r      <= ks_r;
                    out_valid_r <= 1'b1;
                end else if (strm.out_ready) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Bench for rc4_stream_engine: known-answer vectors, backpressure, error and
// restart cases, async reset, and random keys/data against a textbook RC4 model.
module tb_rc4_stream_engine;
    import rc4_pkg::*;

    localparam int DONE_LAT = 2 + KSA_CYCLES;
    localparam int BUDGET   = 400;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [7:0]   key_length = 8'd0;
    logic         sel = 1'b0;
    logic         in_valid_s = 1'b0;
    logic [7:0]   in_data_s = 8'd0;
    logic         out_ready_s = 1'b1;

    logic [7:0] ckey0, ckey4;
    logic       done0, done4, busy0, busy4, err0, err4;
    logic       in_ready_o, out_valid_o, done_o, busy_o, err_o;
    logic [7:0] out_data_o, ckey_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] in_q [$];
    logic [7:0] ks_exp [$];
    logic [7:0] got_d [$];
    logic [7:0] got_k [$];

    rc4_stream_engine_if if0 ();
    rc4_stream_engine_if if4 ();

    assign if0.in_valid  = in_valid_s & ~sel;
    assign if0.in_data   = in_data_s;
    assign if0.out_ready = out_ready_s;
    assign if4.in_valid  = in_valid_s & sel;
    assign if4.in_data   = in_data_s;
    assign if4.out_ready = out_ready_s;

    assign in_ready_o  = sel ? if4.in_ready  : if0.in_ready;
    assign out_valid_o = sel ? if4.out_valid : if0.out_valid;
    assign out_data_o  = sel ? if4.out_data  : if0.out_data;
    assign ckey_o      = sel ? ckey4 : ckey0;
    assign done_o      = sel ? done4 : done0;
    assign busy_o      = sel ? busy4 : busy0;
    assign err_o       = sel ? err4  : err0;

    rc4_stream_engine #(.MAX_KEY_BYTES(16), .DROP_N(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_length(key_length),
        .strm(if0), .ckey(ckey0), .done(done0), .busy(busy0), .err(err0)
    );

    rc4_stream_engine #(.MAX_KEY_BYTES(16), .DROP_N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_length(key_length),
        .strm(if4), .ckey(ckey4), .done(done4), .busy(busy4), .err(err4)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bytes given most-significant first in a right-aligned vector
    task automatic set_in(input logic [127:0] v, input int n);
        in_q.delete();
        for (int k = 0; k < n; k++) in_q.push_back(8'(v >> (8 * (n - 1 - k))));
    endtask

    task automatic set_ks(input logic [127:0] v, input int n);
        ks_exp.delete();
        for (int k = 0; k < n; k++) ks_exp.push_back(8'(v >> (8 * (n - 1 - k))));
    endtask

    // Textbook RC4 (KSA, optional discard, PRGA) producing n keystream bytes
    task automatic rc4_ref(input logic [127:0] k, input int len, input int drop, input int n);
        logic [7:0] s [256];
        logic [7:0] kb [16];
        logic [7:0] ii, jj, tmp;
        logic [3:0] kx;
        for (int m = 0; m < 16; m++) kb[m] = 8'(k >> (8 * m));
        for (int m = 0; m < 256; m++) s[m[7:0]] = m[7:0];
        jj = 8'd0;
        kx = 4'd0;
        for (int m = 0; m < 256; m++) begin
            ii = m[7:0];
            jj = jj + s[ii] + kb[kx];
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            kx = (int'(kx) == len - 1) ? 4'd0 : kx + 4'd1;
        end
        ii = 8'd0;
        jj = 8'd0;
        ks_exp.delete();
        for (int c = 0; c < drop + n; c++) begin
            ii = ii + 8'd1;
            jj = jj + s[ii];
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            if (c >= drop) ks_exp.push_back(s[8'(s[ii] + s[jj])]);
        end
    endtask

    task automatic pulse_start(input logic [127:0] k, input logic [7:0] len);
        @(negedge clk);
        key = k;
        key_length = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start, then measure cycles to done and from done to the first in_ready
    task automatic key_up(input logic [127:0] k, input logic [7:0] len, input int exp_lat);
        int n;
        int m;
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        pulse_start(k, len);
        n = 1;
        check_eq("busy_after_start", 32'(busy_o), 32'd1);
        while (!done_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_latency", 32'(n), 32'(exp_lat));
        m = n;
        #1;
        while (!in_ready_o && m < n + 20) begin
            @(negedge clk);
            m++;
            #1;
        end
        check_eq("first_ready_latency", 32'(m - n), 32'(PRGA_STEP));
    endtask

    // Stream in_q through the selected engine; mode 0 free, 1 random, 2 ten-cycle stall
    task automatic run_stream(input int n, input int mode);
        int sent, got, cyc, stall_left;
        logic held, stalled;
        logic [7:0] hold_d;
        got_d.delete();
        got_k.delete();
        sent = 0; got = 0; cyc = 0; stall_left = 0;
        held = 1'b0; stalled = 1'b0; hold_d = 8'd0;
        while (got < n && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                check_eq("hold_valid", 32'(out_valid_o), 32'd1);
                check_eq("hold_data", 32'(out_data_o), 32'(hold_d));
            end
            if (mode == 2 && got == 2 && !stalled) begin
                stall_left = 10;
                stalled = 1'b1;
            end
            if (stall_left > 0) begin
                out_ready_s = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                out_ready_s = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready_s = 1'b1;
            end
            in_valid_s = (sent < n) && (mode != 1 || $urandom_range(0, 4) != 0);
            in_data_s = (sent < n) ? in_q[sent] : 8'h00;
            #1;
            if (out_valid_o && !out_ready_s) check_eq("stall_in_ready", 32'(in_ready_o), 32'd0);
            held = out_valid_o && !out_ready_s;
            hold_d = out_data_o;
            if (out_valid_o && out_ready_s) begin
                got_d.push_back(out_data_o);
                got_k.push_back(ckey_o);
                got++;
            end
            if (in_valid_s && in_ready_o) sent++;
        end
        in_valid_s = 1'b0;
        out_ready_s = 1'b1;
        check_eq("byte_count", 32'(got), 32'(n));
        for (int k = 0; k < got && k < n; k++) begin
            check_eq($sformatf("out_data[%0d]", k), 32'(got_d[k]), 32'(in_q[k] ^ ks_exp[k]));
            check_eq($sformatf("ckey[%0d]", k), 32'(got_k[k]), 32'(ks_exp[k]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_err"}, 32'(err_o), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check_eq({tag, "_out_data"}, 32'(out_data_o), 32'd0);
        check_eq({tag, "_ckey"}, 32'(ckey_o), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    endtask

    localparam logic [127:0] KEY_KEY    = 128'h79654B;
    localparam logic [127:0] KEY_WIKI   = 128'h696B6957;
    localparam logic [127:0] KEY_SECRET = 128'h746572636553;
    localparam logic [127:0] KEY_12345  = 128'h0504030201;
    localparam logic [127:0] PT_PLAIN   = 128'h506C61696E74657874;
    localparam logic [127:0] KS_KEY     = 128'hEB9F7781B734CA72A7;

    task automatic vector_key();
        set_in(PT_PLAIN, 9);
        set_ks(KS_KEY, 9);
        run_stream(9, 0);
        check_eq("key_vec_last_byte", 32'(got_d.size() > 8 ? got_d[8] : 8'h00), 32'hD3);
    endtask

    initial begin
        logic [127:0] rk;
        int           rlen, rn;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // "Key" / "Plaintext"
        sel = 1'b0;
        key_up(KEY_KEY, 8'd3, DONE_LAT);
        vector_key();

        // "Wiki", then rekey to "Secret" from PRGA
        key_up(KEY_WIKI, 8'd4, DONE_LAT);
        set_in(128'h0, 6);
        set_ks(128'h6044DB6D41B7, 6);
        run_stream(6, 0);
        key_up(KEY_SECRET, 8'd6, DONE_LAT);
        set_in(128'h0, 1);
        set_ks(128'h04, 1);
        run_stream(1, 0);

        // "Wiki" with a ten-cycle downstream stall
        key_up(KEY_WIKI, 8'd4, DONE_LAT);
        set_in(128'h0, 6);
        set_ks(128'h6044DB6D41B7, 6);
        run_stream(6, 2);

        // Illegal length while in PRGA
        pulse_start(KEY_KEY, 8'd0);
        check_eq("err_len0", 32'(err_o), 32'd1);
        check_eq("err_len0_done", 32'(done_o), 32'd1);
        check_eq("err_len0_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check_eq("err_len0_pulse", 32'(err_o), 32'd0);
        check_eq("err_len0_done_kept", 32'(done_o), 32'd1);

        // 01..05 key, then the same key on the drop-4 engine
        key_up(KEY_12345, 8'd5, DONE_LAT);
        set_in(128'h0, 8);
        set_ks(128'hB2396305F03DC027, 8);
        run_stream(8, 0);
        sel = 1'b1;
        key_up(KEY_12345, 8'd5, DONE_LAT + 4 * PRGA_STEP);
        set_in(128'h0, 4);
        set_ks(128'hF03DC027, 4);
        run_stream(4, 0);
        sel = 1'b0;

        // Illegal length mid-KSA, then restart mid-KSA
        pulse_start(KEY_WIKI, 8'd4);
        repeat (100) @(negedge clk);
        pulse_start(KEY_KEY, 8'd17);
        check_eq("err_len17", 32'(err_o), 32'd1);
        check_eq("err_len17_busy", 32'(busy_o), 32'd1);
        check_eq("err_len17_done", 32'(done_o), 32'd0);
        @(negedge clk);
        check_eq("err_len17_pulse", 32'(err_o), 32'd0);
        repeat (50) @(negedge clk);
        key_up(KEY_KEY, 8'd3, DONE_LAT);
        vector_key();

        // Async reset during PRGA with a held output byte
        key_up(KEY_KEY, 8'd3, DONE_LAT);
        @(negedge clk);
        out_ready_s = 1'b0;
        in_valid_s = 1'b1;
        in_data_s = 8'h50;
        #1;
        check_eq("pre_reset_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk);
        in_valid_s = 1'b0;
        check_eq("pre_reset_out_valid", 32'(out_valid_o), 32'd1);
        check_eq("pre_reset_out_data", 32'(out_data_o), 32'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_s = 1'b1;
        key_up(KEY_KEY, 8'd3, DONE_LAT);
        vector_key();

        // Random keys, lengths, data and backpressure on both engines
        for (int it = 0; it < 10; it++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rlen = int'($urandom_range(1, 16));
            rn = int'($urandom_range(4, 16));
            sel = $urandom_range(0, 1) != 0;
            key_up(rk, 8'(rlen), DONE_LAT + (sel ? 4 * PRGA_STEP : 0));
            in_q.delete();
            for (int k = 0; k < rn; k++) in_q.push_back(8'($urandom()));
            rc4_ref(rk, rlen, sel ? 4 : 0, rn);
            run_stream(rn, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
